// File: rtl/quad_pkg.sv
// Shared definitions for the copter command link: opcodes, response codes and frame states.
package quad_pkg;

  localparam logic [7:0] CMD_SET_PITCH  = 8'h02;
  localparam logic [7:0] CMD_SET_ROLL   = 8'h03;
  localparam logic [7:0] CMD_SET_YAW    = 8'h04;
  localparam logic [7:0] CMD_SET_THRST  = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE  = 8'h06;
  localparam logic [7:0] CMD_EMER_LAND  = 8'h07;
  localparam logic [7:0] CMD_MOTORS_OFF = 8'h08;

  localparam logic [7:0] RESP_ACK = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } frame_state_t;

endpackage

// File: rtl/uart_trx.sv
// Full-duplex UART bit engines: 8N1 receiver with framing-error detect and a 10-bit shift transmitter.
module uart_trx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_ferr,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_busy;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;

  logic          tx_busy;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_shift;

  // Receiver: rx_bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bit   <= 4'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_rdy   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_rdy  <= 1'b0;
      rx_ferr <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_baud <= HALF;
          rx_bit  <= 4'd0;
        end
      end else if (rx_baud != '0) begin
        rx_baud <= rx_baud - ONE;
      end else begin
        rx_baud <= FULL;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit <= 4'd8) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end else begin
          rx_busy <= 1'b0;
          if (rx_s2) begin
            rx_data <= rx_shift;
            rx_rdy  <= 1'b1;
          end else begin
            rx_ferr <= 1'b1;
          end
        end
      end
    end
  end

  // Transmitter: tx always mirrors tx_shift[0] of the bit currently on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= 10'h3FF;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else if (!tx_busy) begin
      tx <= 1'b1;
      if (trmt) begin
        tx_busy  <= 1'b1;
        tx_baud  <= FULL;
        tx_bit   <= 4'd0;
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx       <= 1'b0;
        tx_done  <= 1'b0;
      end
    end else if (tx_baud != '0) begin
      tx_baud <= tx_baud - ONE;
    end else begin
      tx_baud <= FULL;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
        tx      <= 1'b1;
      end else begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx       <= tx_shift[1];
        tx_bit   <= tx_bit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles 3-byte host frames {cmd, data_hi, data_lo} into cmd/data with a cmd_rdy level,
// and forwards single response bytes to the host.
module uart_cmd_wrapper
  import quad_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int FRAME_TO = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int TW = $clog2(FRAME_TO + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(FRAME_TO);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [7:0]   rx_data;
  logic         rx_rdy, rx_ferr;
  frame_state_t state;
  logic [7:0]   cmd_shadow, data_hi;
  logic [TW-1:0] to_cnt;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_ferr (rx_ferr),
    .tx_data (resp),
    .trmt    (send_resp),
    .tx      (TX),
    .tx_done (resp_sent)
  );

  // Completion is written after the clear so a same-cycle clr_cmd_rdy loses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_shadow <= 8'h00;
      data_hi    <= 8'h00;
      cmd        <= 8'h00;
      data       <= 16'h0000;
      cmd_rdy    <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (rx_ferr) begin
        state <= IDLE;
      end else if (rx_rdy) begin
        case (state)
          IDLE: begin
            cmd_shadow <= rx_data;
            cmd_rdy    <= 1'b0;
            to_cnt     <= TO_LOAD;
            state      <= HIGH;
          end
          HIGH: begin
            data_hi <= rx_data;
            to_cnt  <= TO_LOAD;
            state   <= LOW;
          end
          LOW: begin
            cmd     <= cmd_shadow;
            data    <= {data_hi, rx_data};
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == '0) state  <= IDLE;
        else              to_cnt <= to_cnt - TO_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: host-side UART driver/receiver with hand-computed expectations.
module tb_uart_cmd_wrapper;

  localparam int BAUD = 32;
  localparam int FTO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int errs = 0;
  int checks = 0;
  logic [7:0] host_q[$];

  uart_cmd_wrapper #(.BAUD_DIV(BAUD), .FRAME_TO(FTO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BAUD);
    end
    RX = stop;
    tick(BAUD);
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(c, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    tick(4);
  endtask

  // Host receiver: samples TX mid-bit and queues each byte with a valid start bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TX);
      repeat (BAUD / 2) @(negedge clk);
      if (TX == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        host_q.push_back(b);
      end
    end
  end

  initial begin
    logic seen;
    tick(3);
    check_val("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_val("rst_cmd", {24'd0, cmd}, 32'h00);
    check_val("rst_data", {16'd0, data}, 32'h0000);
    check_val("rst_tx", {31'd0, TX}, 32'd1);
    check_val("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // 1: basic frame
    send_frame(8'h05, 8'h00, 8'hAA);
    check_val("t1_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check_val("t1_cmd", {24'd0, cmd}, 32'h05);
    check_val("t1_data", {16'd0, data}, 32'h00AA);

    // 2: clear, then new frame with clear coinciding with completion
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check_val("t2_clr", {31'd0, cmd_rdy}, 32'd0);
    check_val("t2_cmd_hold", {24'd0, cmd}, 32'h05);
    check_val("t2_data_hold", {16'd0, data}, 32'h00AA);
    send_byte(8'h02, 1'b1);
    send_byte(8'hFF, 1'b1);
    check_val("t2_partial_data", {16'd0, data}, 32'h00AA);
    seen = 1'b0;
    clr_cmd_rdy = 1'b1;
    fork
      send_byte(8'h80, 1'b1);
      begin
        for (int i = 0; i < 12 * BAUD && !seen; i++) begin
          tick(1);
          if (cmd_rdy) begin
            seen = 1'b1;
            clr_cmd_rdy = 1'b0;
          end
        end
      end
    join
    clr_cmd_rdy = 1'b0;
    tick(3);
    check_val("t2_rise_with_clr", {31'd0, seen}, 32'd1);
    check_val("t2_cmd_rdy_held", {31'd0, cmd_rdy}, 32'd1);
    check_val("t2_cmd", {24'd0, cmd}, 32'h02);
    check_val("t2_data", {16'd0, data}, 32'hFF80);

    // 3: response, second strobe while busy ignored
    host_q.delete();
    resp = 8'hA5;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    check_val("t3_resp_sent_clr", {31'd0, resp_sent}, 32'd0);
    tick(3 * BAUD);
    resp = 8'h00;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    tick(7 * BAUD - 8);
    check_val("t3_resp_sent_early", {31'd0, resp_sent}, 32'd0);
    tick(10);
    check_val("t3_resp_sent", {31'd0, resp_sent}, 32'd1);
    check_val("t3_tx_idle", {31'd0, TX}, 32'd1);
    tick(3 * BAUD);
    check_val("t3_host_count", host_q.size(), 32'd1);
    if (host_q.size() > 0) check_val("t3_host_byte", {24'd0, host_q[0]}, 32'hA5);

    // 4: framing error on data_hi, then a clean frame
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b0);
    tick(2 * BAUD);
    check_val("t4_ferr_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check_val("t4_ferr_cmd", {24'd0, cmd}, 32'h02);
    send_frame(8'h04, 8'h00, 8'h99);
    check_val("t4_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check_val("t4_cmd", {24'd0, cmd}, 32'h04);
    check_val("t4_data", {16'd0, data}, 32'h0099);

    // 5: inter-byte timeout drops the partial frame
    send_byte(8'h06, 1'b1);
    tick(FTO + 10);
    check_val("t5_to_cmd", {24'd0, cmd}, 32'h04);
    send_frame(8'h07, 8'h00, 8'h00);
    check_val("t5_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check_val("t5_cmd", {24'd0, cmd}, 32'h07);
    check_val("t5_data", {16'd0, data}, 32'h0000);

    // 6: reset mid-frame and mid-response
    send_byte(8'h05, 1'b1);
    resp = 8'h00;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    fork
      send_byte(8'h33, 1'b1);
      begin
        tick(4 * BAUD);
        rst_n = 1'b0;
        tick(3);
        check_val("t6_tx", {31'd0, TX}, 32'd1);
        check_val("t6_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check_val("t6_cmd", {24'd0, cmd}, 32'h00);
        check_val("t6_data", {16'd0, data}, 32'h0000);
        check_val("t6_resp_sent", {31'd0, resp_sent}, 32'd0);
        rst_n = 1'b1;
      end
    join
    tick(FTO + 2 * BAUD + 10);
    send_frame(8'h08, 8'h00, 8'h00);
    check_val("t6_cmd_rdy_after", {31'd0, cmd_rdy}, 32'd1);
    check_val("t6_cmd_after", {24'd0, cmd}, 32'h08);
    check_val("t6_data_after", {16'd0, data}, 32'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
